// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
// Optional feature macro used by the arbiter: UART_ARB_TIMEOUT_EN.
package uart_tx_arbiter_pkg;

    typedef logic bit_t;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_START,
        ARB_SEND,
        ARB_REL
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting at the
// pointer, wrapping past the top index, and returns the first set request.
module rr_priority_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output bit_t               any_valid
);

    logic [IDX_W:0]   pos_sum;
    logic [IDX_W-1:0] pos;
    bit_t             found;

    // Walk NUM_REQ positions from the pointer; the first valid one wins and masks the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos_sum   = '0;
        pos       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos_sum >= (IDX_W+1)'(NUM_REQ)) begin
                pos_sum = pos_sum - (IDX_W+1)'(NUM_REQ);
            end
            pos = pos_sum[IDX_W-1:0];
            if (!found && req[pos]) begin
                found       = 1'b1;
                grant[pos]  = 1'b1;
                grant_idx   = pos;
            end
        end
        any_valid = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// It latches the winning byte, holds a level start until the transmitter has
// gone busy and back idle, then releases the link for one cycle.
// Define UART_ARB_TIMEOUT_EN to abort a start the transmitter never acknowledges.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        active,
    output logic                        done,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]  data_d;
    logic [IDX_W-1:0]   grant_d;
    logic [NUM_REQ-1:0] ready_d;
    bit_t               timeout_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    bit_t               pick_any;
    logic [DATA_W-1:0]  pick_data;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (pick_onehot),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // Select the winner's byte with a one-hot mux so the slice indices stay constant.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic; a grant only happens from IDLE with the transmitter idle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = tx_data;
        grant_d   = grant_id;
        ready_d   = '0;
        timeout_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any && !tx_busy) begin
                    ready_d = pick_onehot;
                    data_d  = pick_data;
                    grant_d = pick_idx;
                    ptr_d   = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d = ARB_START;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ARB_START: begin
                if (tx_busy) begin
                    state_d = ARB_SEND;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = ARB_REL;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ARB_SEND: begin
                if (!tx_busy) begin
                    state_d = ARB_REL;
                end
            end
            ARB_REL: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Register state and every output; outputs are derived from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            req_ready   <= ready_d;
            tx_start    <= (state_d == ARB_START) || (state_d == ARB_SEND);
            tx_data     <= data_d;
            grant_id    <= grant_d;
            active      <= (state_d != ARB_IDLE);
            done        <= (state_d == ARB_REL);
            timeout_err <= timeout_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Cycles spent in START waiting for the transmitter to report busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle-by-cycle vector table for
// reset, single request and wrap/skip, plus hand-written fairness, busy-at-reset
// and start-timeout sequences (timeout variant follows UART_ARB_TIMEOUT_EN).
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam logic [31:0] REQ_BYTES = 32'h44A5_2211;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        done;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       busy;
        logic [3:0] ready;
        logic       start;
        logic [7:0] data;
        logic [1:0] grant;
        logic       act;
        logic       dn;
    } vec_t;

    vec_t vecs[$];

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .done        (done),
        .timeout_err (timeout_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] byte_of(input int idx);
        logic [31:0] b;
        b = REQ_BYTES;
        return b[idx*8 +: 8];
    endfunction

    function automatic void add_vec(input logic rst, input logic [3:0] valid, input logic busy,
                                    input logic [3:0] ready, input logic start, input logic [7:0] data,
                                    input logic [1:0] grant, input logic act, input logic dn);
        vec_t v;
        v.rst = rst; v.valid = valid; v.busy = busy;
        v.ready = ready; v.start = start; v.data = data;
        v.grant = grant; v.act = act; v.dn = dn;
        vecs.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        req_valid = v.valid;
        tx_busy   = v.busy;
        step();
    endtask

    task automatic do_reset(input logic busy);
        reset     = 1'b1;
        req_valid = 4'b0000;
        tx_busy   = busy;
        step();
        step();
        reset = 1'b0;
    endtask

    // One byte of the fairness run: wait for the grant, check it, then model a short frame.
    task automatic fair_byte(input int exp_idx, input int exp_gap);
        int k;
        k = 0;
        step();
        k++;
        while (req_ready == 4'b0000 && k < 20) begin
            step();
            k++;
        end
        checkOutput($sformatf("fair%0d gap", exp_idx), k, exp_gap);
        checkOutput($sformatf("fair%0d ready", exp_idx), req_ready, 32'(1) << exp_idx);
        checkOutput($sformatf("fair%0d grant", exp_idx), grant_id, exp_idx);
        checkOutput($sformatf("fair%0d data", exp_idx), tx_data, byte_of(exp_idx));
        checkOutput($sformatf("fair%0d start", exp_idx), tx_start, 1);
        tx_busy = 1'b1;
        repeat (3) step();
        tx_busy = 1'b0;
        k = 0;
        step();
        while (!done && k < 10) begin
            step();
            k++;
        end
        checkOutput($sformatf("fair%0d done", exp_idx), done, 1);
        checkOutput($sformatf("fair%0d start low", exp_idx), tx_start, 0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = REQ_BYTES;
        tx_busy   = 1'b0;

        // Reset, single request on port 2, then wrap/skip from pointer 3.
        add_vec(1, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        add_vec(1, 4'b1111, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        add_vec(0, 4'b0100, 0, 4'b0100, 1, 8'hA5, 2, 1, 0);
        add_vec(0, 4'b0000, 0, 4'b0000, 1, 8'hA5, 2, 1, 0);
        for (int i = 0; i < 10; i++) add_vec(0, 4'b0000, 1, 4'b0000, 1, 8'hA5, 2, 1, 0);
        add_vec(0, 4'b0000, 0, 4'b0000, 0, 8'hA5, 2, 1, 1);
        add_vec(0, 4'b0000, 0, 4'b0000, 0, 8'hA5, 2, 0, 0);
        add_vec(0, 4'b0011, 0, 4'b0001, 1, 8'h11, 0, 1, 0);
        add_vec(0, 4'b0011, 1, 4'b0000, 1, 8'h11, 0, 1, 0);
        add_vec(0, 4'b0011, 0, 4'b0000, 0, 8'h11, 0, 1, 1);
        add_vec(0, 4'b0011, 0, 4'b0000, 0, 8'h11, 0, 0, 0);
        add_vec(0, 4'b0011, 0, 4'b0010, 1, 8'h22, 1, 1, 0);
        add_vec(0, 4'b0011, 1, 4'b0000, 1, 8'h22, 1, 1, 0);
        add_vec(0, 4'b1000, 0, 4'b0000, 0, 8'h22, 1, 1, 1);
        add_vec(0, 4'b1000, 0, 4'b0000, 0, 8'h22, 1, 0, 0);
        add_vec(0, 4'b1000, 0, 4'b1000, 1, 8'h44, 3, 1, 0);
        add_vec(0, 4'b0000, 1, 4'b0000, 1, 8'h44, 3, 1, 0);
        add_vec(0, 4'b0000, 0, 4'b0000, 0, 8'h44, 3, 1, 1);
        add_vec(0, 4'b0000, 0, 4'b0000, 0, 8'h44, 3, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d ready", i), req_ready, vecs[i].ready);
            checkOutput($sformatf("v%0d start", i), tx_start, vecs[i].start);
            checkOutput($sformatf("v%0d data", i), tx_data, vecs[i].data);
            checkOutput($sformatf("v%0d grant", i), grant_id, vecs[i].grant);
            checkOutput($sformatf("v%0d active", i), active, vecs[i].act);
            checkOutput($sformatf("v%0d done", i), done, vecs[i].dn);
            checkOutput($sformatf("v%0d terr", i), timeout_err, 0);
        end

        // Fairness: all four requesting for eight bytes.
        do_reset(1'b0);
        req_valid = 4'b1111;
        for (int b = 0; b < 8; b++) begin
            fair_byte(b % 4, (b == 0) ? 1 : 2);
        end
        req_valid = 4'b0000;
        step();

        // Transmitter still busy after reset: no grant until it goes idle.
        reset     = 1'b1;
        tx_busy   = 1'b1;
        req_valid = 4'b0001;
        step();
        step();
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            checkOutput($sformatf("busyrst c%0d ready", c), req_ready, 0);
            checkOutput($sformatf("busyrst c%0d active", c), active, 0);
        end
        tx_busy = 1'b0;
        step();
        checkOutput("busyrst ready", req_ready, 4'b0001);
        checkOutput("busyrst data", tx_data, 8'h11);
        checkOutput("busyrst start", tx_start, 1);
        tx_busy = 1'b1;
        step();
        tx_busy   = 1'b0;
        req_valid = 4'b0000;
        step();
        checkOutput("busyrst done", done, 1);
        step();

        // Transmitter never acknowledges the start.
        do_reset(1'b0);
        req_valid = 4'b0011;
        step();
        checkOutput("tmo first ready", req_ready, 4'b0001);
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            while (!timeout_err && cyc < 200) begin
                step();
                cyc++;
            end
            checkOutput("tmo cycle", cyc, TIMEOUT_CYC);
            checkOutput("tmo start", tx_start, 0);
            checkOutput("tmo done", done, 1);
            step();
            checkOutput("tmo err pulse", timeout_err, 0);
            step();
            checkOutput("tmo next ready", req_ready, 4'b0010);
            checkOutput("tmo next grant", grant_id, 1);
            req_valid = 4'b0000;
            tx_busy   = 1'b1;
            step();
            tx_busy = 1'b0;
            step();
            checkOutput("tmo next done", done, 1);
        end
`else
        begin
            logic saw_err;
            logic saw_drop;
            saw_err  = 1'b0;
            saw_drop = 1'b0;
            req_valid = 4'b0000;
            for (int c = 0; c < 100; c++) begin
                step();
                if (timeout_err) saw_err = 1'b1;
                if (!tx_start || done) saw_drop = 1'b1;
            end
            checkOutput("notmo err", saw_err, 0);
            checkOutput("notmo start held", saw_drop, 0);
            checkOutput("notmo active", active, 1);
            tx_busy = 1'b1;
            step();
            tx_busy = 1'b0;
            step();
            checkOutput("notmo done", done, 1);
        end
`endif
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
